// File: rtl/obi_host_port.sv
// Single-outstanding OBI host port: turns a valid/ready command into a bus request and returns one response.
// Optional response timeout is compiled in with `define OBI_HOST_PORT_TIMEOUT_EN.
module obi_host_port #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic                  cmd_we_i,
   input  logic [3:0]            cmd_be_i,
   input  logic [31:0]           cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  req_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  we_o,
   output logic [3:0]            be_o,
   output logic [31:0]           wdata_o,
   input  logic                  gnt_i,
   input  logic                  rvalid_i,
   input  logic [31:0]           rdata_i
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("obi_host_port: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RSP} state_t;

   state_t      state;
   state_t      state_next;
   logic        load_cmd;
   logic        load_rsp;
   logic [31:0] rsp_rdata_next;
   logic        rsp_err_next;

`ifdef OBI_HOST_PORT_TIMEOUT_EN
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] wait_cnt;
   logic       timeout_hit;

   // Fires on the WAIT_R cycle that would bring the count up to the limit.
   assign timeout_hit = (wait_cnt + 8'd1) == LIMIT;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_cnt <= 8'd0;
      end else if (state != WAIT_R) begin
         wait_cnt <= 8'd0;
      end else if (!rvalid_i) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`endif

   always_comb begin
      state_next     = state;
      load_cmd       = 1'b0;
      load_rsp       = 1'b0;
      rsp_rdata_next = 32'd0;
      rsp_err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_be_i != 4'd0) begin
                  load_cmd   = 1'b1;
                  state_next = REQ;
               end else begin
                  load_rsp     = 1'b1;
                  rsp_err_next = 1'b1;
                  state_next   = RSP;
               end
            end
         end
         REQ: begin
            if (gnt_i) state_next = WAIT_R;
         end
         WAIT_R: begin
            // A response arriving on the limit cycle still wins over the timeout.
            if (rvalid_i) begin
               load_rsp       = 1'b1;
               rsp_rdata_next = we_o ? 32'd0 : rdata_i;
               state_next     = RSP;
            end
`ifdef OBI_HOST_PORT_TIMEOUT_EN
            else if (timeout_hit) begin
               load_rsp       = 1'b1;
               rsp_err_next   = 1'b1;
               rsp_rdata_next = 32'hDEADBEEF;
               state_next     = RSP;
            end
`endif
         end
         RSP: begin
            if (rsp_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         addr_o      <= '0;
         we_o        <= 1'b0;
         be_o        <= 4'd0;
         wdata_o     <= 32'd0;
         rsp_rdata_o <= 32'd0;
         rsp_err_o   <= 1'b0;
      end else begin
         state <= state_next;
         if (load_cmd) begin
            addr_o  <= cmd_addr_i;
            we_o    <= cmd_we_i;
            be_o    <= cmd_be_i;
            wdata_o <= cmd_wdata_i;
         end
         if (load_rsp) begin
            rsp_rdata_o <= rsp_rdata_next;
            rsp_err_o   <= rsp_err_next;
         end
      end
   end

   // Ready is masked during reset so every output reads 0 while rst_i is high.
   assign cmd_ready_o = (state == IDLE) && !rst_i;
   assign req_o       = (state == REQ);
   assign rsp_valid_o = (state == RSP);

endmodule

// File: tb/tb_obi_host_port.sv
// Self-checking bench for obi_host_port: transaction-timing model with random stimulus plus directed cases.
module tb_obi_host_port;

   localparam int TMO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [31:0] cmd_addr_i = '0;
   logic        cmd_we_i = 1'b0;
   logic [3:0]  cmd_be_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        req_o;
   logic [31:0] addr_o;
   logic        we_o;
   logic [3:0]  be_o;
   logic [31:0] wdata_o;
   logic        gnt_i = 1'b0;
   logic        rvalid_i = 1'b0;
   logic [31:0] rdata_i = '0;

   obi_host_port #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
      .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Model: the last accepted request fields and the last response, plus per-cycle expectations.
   logic [31:0] held_addr, held_wdata, held_rdata;
   logic        held_we, held_err;
   logic [3:0]  held_be;
   logic        exp_cmd_ready, exp_req, exp_rsp_valid, exp_we, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;
   bit          mon_en = 1'b0;
   int          cur_k = -1;

   int          obs_req_cnt, obs_rsp_cnt, obs_rsp_k;
   logic [31:0] obs_rdata;
   logic        obs_err, obs_err_at2;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle on the falling edge and record transaction observations.
   always @(negedge clk_i) begin
      if (mon_en) begin
         checkOutput("cmd_ready", 32'(cmd_ready_o), 32'(exp_cmd_ready));
         checkOutput("req", 32'(req_o), 32'(exp_req));
         checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp_valid));
         checkOutput("addr", addr_o, exp_addr);
         checkOutput("we", 32'(we_o), 32'(exp_we));
         checkOutput("be", 32'(be_o), 32'(exp_be));
         checkOutput("wdata", wdata_o, exp_wdata);
         checkOutput("rsp_rdata", rsp_rdata_o, exp_rdata);
         checkOutput("rsp_err", 32'(rsp_err_o), 32'(exp_err));
         if (cur_k == 0) begin
            obs_req_cnt = 0;
            obs_rsp_cnt = 0;
            obs_rsp_k   = -1;
            obs_err_at2 = 1'b0;
         end
         if (cur_k >= 0) begin
            if (req_o) obs_req_cnt++;
            if (rsp_valid_o) begin
               obs_rsp_cnt++;
               if (obs_rsp_k < 0) begin
                  obs_rsp_k = cur_k;
                  obs_rdata = rsp_rdata_o;
                  obs_err   = rsp_err_o;
               end
            end
            if (cur_k == 2) obs_err_at2 = rsp_err_o;
         end
      end
   end

   task automatic setIdleExpect();
      exp_cmd_ready = 1'b1;
      exp_req       = 1'b0;
      exp_rsp_valid = 1'b0;
      exp_addr      = held_addr;
      exp_we        = held_we;
      exp_be        = held_be;
      exp_wdata     = held_wdata;
      exp_rdata     = held_rdata;
      exp_err       = held_err;
   endtask

   task automatic clearHeld();
      held_addr = '0; held_we = 1'b0; held_be = '0; held_wdata = '0;
      held_rdata = '0; held_err = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic randomNoise();
      cmd_valid_i = 1'b0;
      cmd_addr_i  = $urandom;
      cmd_we_i    = 1'($urandom);
      cmd_be_i    = 4'($urandom);
      cmd_wdata_i = $urandom;
      gnt_i       = 1'($urandom);
      rvalid_i    = 1'($urandom);
      rdata_i     = $urandom;
      rsp_ready_i = 1'($urandom);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         cur_k = -1;
         randomNoise();
         setIdleExpect();
         nextCycle();
      end
   endtask

   // One transaction starting in an IDLE cycle: g = grant delay, r = rvalid delay in WAIT_R, d = ready delay.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input int g, input int r,
                                input logic [31:0] rdata, input int d);
      int          s;
      int          w;
      logic        tmo;
      logic [31:0] exp_rd;
      logic        exp_e;
      tmo = 1'b0;
      w   = r;
`ifdef OBI_HOST_PORT_TIMEOUT_EN
      if (r >= TMO) begin
         w   = TMO - 1;
         tmo = 1'b1;
      end
`endif
      if (be == 4'd0) begin
         s = 1; exp_rd = 32'd0; exp_e = 1'b1;
      end else begin
         s      = 3 + g + w;
         exp_e  = tmo;
         exp_rd = tmo ? 32'hDEADBEEF : (we ? 32'd0 : rdata);
      end
      for (int k = 0; k <= s + d; k++) begin
         cur_k = k;
         randomNoise();
         if (k == 0) begin
            cmd_valid_i = 1'b1;
            cmd_addr_i  = addr;
            cmd_we_i    = we;
            cmd_be_i    = be;
            cmd_wdata_i = wdata;
         end else begin
            cmd_valid_i = 1'($urandom);
         end
         if (be != 4'd0) begin
            if (k >= 1 && k <= 1 + g) gnt_i = (k == 1 + g);
            if (k >= 2 + g && k < s) rvalid_i = 1'b0;
            if (k == 2 + g + r) begin
               rvalid_i = 1'b1;
               rdata_i  = rdata;
            end
         end
         if (k >= s) rsp_ready_i = (k == s + d);
         if (k == 1 && be != 4'd0) begin
            held_addr = addr; held_we = we; held_be = be; held_wdata = wdata;
         end
         if (k == s) begin
            held_rdata = exp_rd;
            held_err   = exp_e;
         end
         setIdleExpect();
         exp_cmd_ready = (k == 0);
         exp_req       = (be != 4'd0) && (k >= 1) && (k <= 1 + g);
         exp_rsp_valid = (k >= s);
         nextCycle();
      end
   endtask

   initial begin
      logic [31:0] rst_wdata;
      clearHeld();
      #1 rst_i = 1'b1;
      #1;
      checkOutput("reset cmd_ready", 32'(cmd_ready_o), 32'd0);
      checkOutput("reset req", 32'(req_o), 32'd0);
      checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset addr", addr_o, 32'd0);
      checkOutput("reset rdata", rsp_rdata_o, 32'd0);
      checkOutput("reset err", 32'(rsp_err_o), 32'd0);
      setIdleExpect();
      exp_cmd_ready = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      idleCycles(2);

      // Minimum-latency read.
      applyStimulus(1'b0, 32'h1000, 4'hF, 32'h0, 0, 0, 32'hCAFEF00D, 0);
      checkOutput("read latency", 32'(obs_rsp_k), 32'd3);
      checkOutput("read rdata", obs_rdata, 32'hCAFEF00D);
      checkOutput("read err", 32'(obs_err), 32'd0);
      checkOutput("read req cycles", 32'(obs_req_cnt), 32'd1);

      // Write with grant delayed five cycles.
      applyStimulus(1'b1, 32'h2004, 4'b0110, 32'h12345678, 5, 1, 32'hFFFF0000, 1);
      checkOutput("write req cycles", 32'(obs_req_cnt), 32'd6);
      checkOutput("write rdata", obs_rdata, 32'd0);
      checkOutput("write err", 32'(obs_err), 32'd0);
      checkOutput("write addr held", addr_o, 32'h2004);

      // Zero byte enables: error without a bus request.
      applyStimulus(1'b0, 32'h3000, 4'h0, 32'h0, 0, 0, 32'h0, 2);
      checkOutput("be0 req cycles", 32'(obs_req_cnt), 32'd0);
      checkOutput("be0 rsp cycle", 32'(obs_rsp_k), 32'd1);
      checkOutput("be0 err", 32'(obs_err), 32'd1);
      checkOutput("be0 err two after", 32'(obs_err_at2), 32'd1);
      checkOutput("be0 rdata", obs_rdata, 32'd0);

      // Response held for ten cycles before being consumed.
      applyStimulus(1'b0, 32'h4000, 4'hF, 32'h0, 1, 2, 32'h0BADF00D, 10);
      checkOutput("hold rsp cycles", 32'(obs_rsp_cnt), 32'd11);
      checkOutput("hold rsp start", 32'(obs_rsp_k), 32'd6);

`ifdef OBI_HOST_PORT_TIMEOUT_EN
      applyStimulus(1'b0, 32'h5000, 4'hF, 32'h0, 0, 5, 32'h11111111, 3);
      checkOutput("timeout rsp start", 32'(obs_rsp_k), 32'd6);
      checkOutput("timeout rdata", obs_rdata, 32'hDEADBEEF);
      checkOutput("timeout err", 32'(obs_err), 32'd1);
      applyStimulus(1'b0, 32'h5004, 4'hF, 32'h0, 0, 3, 32'h22222222, 0);
      checkOutput("limit rvalid start", 32'(obs_rsp_k), 32'd6);
      checkOutput("limit rvalid rdata", obs_rdata, 32'h22222222);
      checkOutput("limit rvalid err", 32'(obs_err), 32'd0);
`else
      applyStimulus(1'b0, 32'h5000, 4'hF, 32'h0, 0, 20, 32'h33333333, 0);
      checkOutput("long wait start", 32'(obs_rsp_k), 32'd23);
      checkOutput("long wait err", 32'(obs_err), 32'd0);
`endif

      // Reset pulsed while waiting for the response.
      cur_k = -1;
      randomNoise();
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_be_i = 4'hF; cmd_addr_i = 32'h44440000;
      rst_wdata = cmd_wdata_i;
      setIdleExpect();
      nextCycle();
      randomNoise();
      gnt_i = 1'b1;
      held_addr = 32'h44440000; held_we = 1'b0; held_be = 4'hF; held_wdata = rst_wdata;
      setIdleExpect(); exp_cmd_ready = 1'b0; exp_req = 1'b1;
      nextCycle();
      randomNoise();
      rvalid_i = 1'b0;
      setIdleExpect(); exp_cmd_ready = 1'b0;
      #2 rst_i = 1'b1;
      clearHeld();
      setIdleExpect(); exp_cmd_ready = 1'b0;
      #1;
      checkOutput("wait reset cmd_ready", 32'(cmd_ready_o), 32'd0);
      checkOutput("wait reset req", 32'(req_o), 32'd0);
      checkOutput("wait reset addr", addr_o, 32'd0);
      checkOutput("wait reset be", 32'(be_o), 32'd0);
      checkOutput("wait reset wdata", wdata_o, 32'd0);
      checkOutput("wait reset rsp_valid", 32'(rsp_valid_o), 32'd0);
      nextCycle();
      nextCycle();
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         randomNoise();
         rvalid_i = 1'b1;
         setIdleExpect();
         nextCycle();
      end
      applyStimulus(1'b0, 32'h6000, 4'hF, 32'h0, 0, 0, 32'h600DCAFE, 0);
      checkOutput("post reset rdata", obs_rdata, 32'h600DCAFE);

      // Random traffic.
      for (int n = 0; n < 150; n++) begin
         logic [3:0] rbe;
         rbe = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         applyStimulus(1'($urandom), $urandom, rbe, $urandom, $urandom_range(0, 4),
                       $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/obi_host_port.md
OBI_HOST_PORT -- requirements
Module: obi_host_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of cmd_addr_i and addr_o.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, legal range 1..255: maximum cycles in WAIT_R before timeout.
REQ-003 SHALL have one clock and one asynchronous, active-high reset.
REQ-004 SHALL have port clk_i, in, 1: clock, all state updates on rising edge.
REQ-005 SHALL have port rst_i, in, 1: asynchronous reset, active-high.
REQ-006 SHALL have port cmd_valid_i, in, 1: command offered.
REQ-007 SHALL have port cmd_ready_o, out, 1: command accepted when cmd_valid_i is also high.
REQ-008 SHALL have port cmd_addr_i, in, ADDR_WIDTH: byte address.
REQ-009 SHALL have port cmd_we_i, in, 1: 1 = write, 0 = read.
REQ-010 SHALL have port cmd_be_i, in, 4: byte enables.
REQ-011 SHALL have port cmd_wdata_i, in, 32: write data.
REQ-012 SHALL have port rsp_valid_o, out, 1: response available.
REQ-013 SHALL have port rsp_ready_i, in, 1: response consumed.
REQ-014 SHALL have port rsp_rdata_o, out, 32: read data, 0 for writes.
REQ-015 SHALL have port rsp_err_o, out, 1: error response.
REQ-016 SHALL have ports req_o (out, 1), addr_o (out, ADDR_WIDTH), we_o (out, 1), be_o (out, 4) and wdata_o (out, 32): bus request channel to the responder.
REQ-017 SHALL have ports gnt_i (in, 1), rvalid_i (in, 1) and rdata_i (in, 32): responder grant and response.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT_R and RSP, with at most one transaction outstanding.
REQ-019 SHALL drive cmd_ready_o = 1 only in IDLE.
REQ-020 On an IDLE handshake with cmd_be_i != 0, SHALL register addr/we/be/wdata and move to REQ; req_o SHALL be high from the next cycle.
REQ-021 On an IDLE handshake with cmd_be_i == 0, SHALL move to RSP with rsp_err_o=1 and rsp_rdata_o=0, and SHALL NOT assert req_o.
REQ-022 In REQ, req_o SHALL be 1, and addr_o/we_o/be_o/wdata_o SHALL be held stable until the cycle in which gnt_i=1; on gnt_i SHALL move to WAIT_R, and req_o SHALL drop in the next cycle.
REQ-023 Outside REQ, req_o SHALL be 0 and addr_o/we_o/be_o/wdata_o SHALL hold their last values.
REQ-024 rvalid_i SHALL be honoured only in WAIT_R; an rvalid_i in the same cycle as gnt_i, or in IDLE/REQ/RSP, SHALL be ignored.
REQ-025 In WAIT_R, on rvalid_i SHALL move to RSP with rsp_err_o=0; rsp_rdata_o SHALL be rdata_i for reads and 0 for writes.
REQ-026 In RSP, rsp_valid_o SHALL be 1 and rsp_rdata_o/rsp_err_o SHALL be stable; on rsp_ready_i SHALL return to IDLE.
REQ-027 A new command SHALL be acceptable no earlier than the cycle after the response handshake.
REQ-028 Minimum command-accept to rsp_valid_o latency SHALL be 3 cycles, given gnt_i in the first REQ cycle and rvalid_i in the first WAIT_R cycle.

Reset
REQ-029 While rst_i is high, SHALL force state IDLE and set req_o, rsp_valid_o and rsp_err_o to 0, addr_o/we_o/be_o/wdata_o/rsp_rdata_o to 0, and the timeout counter to 0, independent of clk_i.
REQ-030 Reset asserted mid-transaction SHALL abandon it silently; a stale rvalid_i after reset release SHALL be ignored.

Configuration
REQ-031 Macro OBI_HOST_PORT_TIMEOUT_EN SHALL compile in the response timeout.
REQ-032 With the macro defined, an 8-bit counter SHALL clear on entry to WAIT_R and increment each WAIT_R cycle without rvalid_i.
REQ-033 With the macro defined, when the counter reaches TIMEOUT_CYCLES, SHALL move to RSP with rsp_err_o=1 and rsp_rdata_o=32'hDEADBEEF.
REQ-034 With the macro defined, rvalid_i in the same cycle the limit is reached SHALL win and produce a normal response.
REQ-035 Without the macro, no counter SHALL exist and WAIT_R SHALL wait indefinitely; rsp_err_o SHALL only arise from REQ-021.

Verification
REQ-036 SHALL cover: read at addr 0x1000, gnt_i in the first REQ cycle, rvalid_i next cycle with rdata 0xCAFEF00D -> rsp_valid_o on cycle 3, rdata 0xCAFEF00D, err 0.
REQ-037 SHALL cover: write with gnt_i delayed 5 cycles -> req_o high for 6 cycles with addr/be/wdata constant; rsp rdata 0, err 0.
REQ-038 SHALL cover: cmd_be_i=0 -> req_o never asserted; rsp_err_o=1 two cycles after accept.
REQ-039 SHALL cover: with the macro and TIMEOUT_CYCLES=4, no rvalid_i -> rsp_err_o=1 with rdata 0xDEADBEEF; a late rvalid_i is ignored and the next command completes normally.
REQ-040 SHALL cover: rsp_ready_i held low 10 cycles -> response stable and cmd_ready_o=0 throughout; rst_i pulsed in WAIT_R -> all outputs 0 immediately, state IDLE.
